// File: rtl/bmu_pkg.sv
// Shared types and helpers for the BMU count sequencer (CLZ/CTZ/CPOP).
// bit_reverse works on the widest supported operand; callers truncate to XLEN.
package bmu_pkg;

    typedef enum logic [1:0] {
        CLZ  = 2'b00,
        CTZ  = 2'b01,
        CPOP = 2'b10,
        RSVD = 2'b11
    } count_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } count_state_t;

    localparam int MAX_XLEN = 64;

    // Reverses the low 'width' bits of v into the low 'width' bits of the result.
    function automatic logic [MAX_XLEN-1:0] bit_reverse(input logic [MAX_XLEN-1:0] v,
                                                        input int unsigned width);
        logic [MAX_XLEN-1:0] r;
        for (int i = 0; i < MAX_XLEN; i++) begin
            r[MAX_XLEN-1-i] = v[i];
        end
        return r >> (MAX_XLEN - width);
    endfunction

endpackage

// File: rtl/nibble_scan_unit.sv
// Combinational per-nibble counts: zero test, leading-zero count, population count.
module nibble_scan_unit (
    input  logic [3:0] i_nib,
    output logic       o_all_zero,
    output logic [1:0] o_lz_count,
    output logic [2:0] o_pop_count
);

    assign o_all_zero = (i_nib == 4'b0000);

    // lz_count is only consumed when the nibble is non-zero.
    always_comb begin
        if (i_nib[3])      o_lz_count = 2'd0;
        else if (i_nib[2]) o_lz_count = 2'd1;
        else if (i_nib[1]) o_lz_count = 2'd2;
        else               o_lz_count = 2'd3;
    end

    assign o_pop_count = {2'b00, i_nib[0]} + {2'b00, i_nib[1]}
                       + {2'b00, i_nib[2]} + {2'b00, i_nib[3]};

endmodule

// File: rtl/bmu_count_sequencer.sv
// Nibble-serial CLZ/CTZ/CPOP sequencer with valid/ready on both sides.
// CTZ is executed as CLZ on the bit-reversed operand.
module bmu_count_sequencer
    import bmu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] operand_i,
    input  logic [1:0]      operation_i,
    input  logic            kill_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int NIBBLES = XLEN / 4;
    localparam int ACC_W   = $clog2(XLEN) + 1;
    localparam int PTR_W   = $clog2(NIBBLES);
    localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(NIBBLES - 1);

    count_state_t     r_state, w_state_nxt;
    count_op_t        r_op;
    logic [XLEN-1:0]  r_operand;
    logic [ACC_W-1:0] r_acc;
    logic [PTR_W-1:0] r_ptr;
    logic             r_valid;
    logic [XLEN-1:0]  r_result;

    count_op_t        w_op_in;
    logic             w_accept;
    logic [3:0]       w_nib;
    logic             w_all_zero;
    logic [1:0]       w_lz;
    logic [2:0]       w_pop;
    logic [2:0]       w_inc;
    logic             w_last;
    logic             w_stop;

    assign w_op_in  = count_op_t'(operation_i);
    assign ready_o  = (r_state == IDLE) & ~rst_i & ~kill_i;
    assign w_accept = valid_i & ready_o;
    assign busy_o   = (r_state != IDLE);
    assign valid_o  = r_valid;
    assign result_o = r_result;

    assign w_nib = r_operand[{r_ptr, 2'b00} +: 4];

    nibble_scan_unit u_scan (
        .i_nib       (w_nib),
        .o_all_zero  (w_all_zero),
        .o_lz_count  (w_lz),
        .o_pop_count (w_pop)
    );

    // CPOP always walks every nibble; CLZ/CTZ stop at the first set nibble.
    assign w_last = (r_ptr == '0);
    assign w_inc  = (r_op == CPOP) ? w_pop : (w_all_zero ? 3'd4 : {1'b0, w_lz});
    assign w_stop = ((r_op == CPOP) || w_all_zero) ? w_last : 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = (w_op_in == RSVD) ? DONE : SCAN;
            SCAN:    if (w_stop) w_state_nxt = DONE;
            DONE:    if (r_valid && ready_i) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (kill_i) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_op      <= CLZ;
            r_operand <= '0;
            r_acc     <= '0;
            r_ptr     <= PTR_TOP;
            r_valid   <= 1'b0;
            r_result  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (kill_i) begin
                r_valid <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_accept) begin
                            r_operand <= (w_op_in == CTZ)
                                       ? XLEN'(bit_reverse(MAX_XLEN'(operand_i), XLEN))
                                       : operand_i;
                            r_op      <= w_op_in;
                            r_acc     <= '0;
                            r_ptr     <= PTR_TOP;
                        end
                    end
                    SCAN: begin
                        r_acc <= r_acc + ACC_W'(w_inc);
                        if (!w_stop) r_ptr <= r_ptr - 1'b1;
                    end
                    DONE: begin
                        // valid/result register one cycle after entering DONE and hold until taken.
                        if (r_valid && ready_i) begin
                            r_valid <= 1'b0;
                        end else begin
                            r_valid  <= 1'b1;
                            r_result <= XLEN'(r_acc);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bmu_count_sequencer.sv
// Directed + randomized bench for bmu_count_sequencer (XLEN=32) against a bit-level count model.
module tb_bmu_count_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] operand_i;
    logic [1:0]  operation_i;
    logic        kill_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic        busy_o;

    int n_vec = 0;
    int n_err = 0;

    bmu_count_sequencer #(.XLEN(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .operand_i   (operand_i),
        .operation_i (operation_i),
        .kill_i      (kill_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .result_o    (result_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: counts from bit-level definitions; latency = nibbles scanned + 1.
    function automatic void model(input logic [1:0] op, input logic [31:0] v,
                                  output logic [31:0] res, output int lat);
        int  cnt;
        bit  seen;
        cnt  = 0;
        seen = 0;
        case (op)
            2'b00: begin
                for (int i = 31; i >= 0; i--) begin
                    if (v[i]) seen = 1;
                    else if (!seen) cnt++;
                end
                lat = (cnt == 32) ? 9 : cnt / 4 + 2;
            end
            2'b01: begin
                for (int i = 0; i < 32; i++) begin
                    if (v[i]) seen = 1;
                    else if (!seen) cnt++;
                end
                lat = (cnt == 32) ? 9 : cnt / 4 + 2;
            end
            2'b10: begin
                for (int i = 0; i < 32; i++) cnt += int'(v[i]);
                lat = 9;
            end
            default: lat = 1;
        endcase
        res = 32'(cnt);
    endfunction

    task automatic do_op(input logic [1:0] op, input logic [31:0] v, input int hold);
        logic [31:0] exp_r;
        int          exp_lat;
        int          n;
        model(op, v, exp_r, exp_lat);
        @(negedge clk_i);
        chk("ready_before_issue", ready_o, 1);
        valid_i     = 1'b1;
        operation_i = op;
        operand_i   = v;
        @(posedge clk_i);
        #1;
        valid_i     = 1'b0;
        operand_i   = $urandom;
        operation_i = 2'($urandom);
        n = 0;
        while (!valid_o && n < 40) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        chk("latency", 64'(n), 64'(exp_lat));
        chk("result", result_o, exp_r);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk_i);
            #1;
            chk("hold_valid", valid_o, 1);
            chk("hold_result", result_o, exp_r);
            chk("hold_ready_low", ready_o, 0);
        end
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        chk("valid_dropped", valid_o, 0);
        chk("ready_after_xfer", ready_o, 1);
        chk("idle_after_xfer", busy_o, 0);
    endtask

    initial begin
        logic [31:0] v;
        rst_i       = 1'b1;
        valid_i     = 1'b0;
        operand_i   = '0;
        operation_i = 2'b00;
        kill_i      = 1'b0;
        ready_i     = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ready", ready_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        do_op(2'b00, 32'h8000_0000, 0);
        do_op(2'b00, 32'h0000_0001, 0);
        do_op(2'b00, 32'h0000_0000, 0);
        do_op(2'b01, 32'h0000_0100, 0);
        do_op(2'b01, 32'h0000_0000, 0);
        do_op(2'b10, 32'hF0F0_00FF, 0);
        do_op(2'b10, 32'hFFFF_FFFF, 0);
        do_op(2'b00, 32'h0010_0000, 5);
        do_op(2'b11, 32'hDEAD_BEEF, 1);
        do_op(2'b01, 32'h8000_0000, 0);

        // Flush during the third cycle of a CPOP.
        @(negedge clk_i);
        valid_i = 1'b1; operation_i = 2'b10; operand_i = 32'hFFFF_0000;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        kill_i = 1'b1;
        @(posedge clk_i);
        #1;
        kill_i = 1'b0;
        chk("kill_busy", busy_o, 0);
        chk("kill_valid", valid_o, 0);
        #1;
        chk("kill_ready", ready_o, 1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_i);
            #1;
            chk("kill_no_valid", valid_o, 0);
        end

        // Kill coincident with a request: not accepted.
        @(negedge clk_i);
        valid_i = 1'b1; kill_i = 1'b1; operation_i = 2'b10; operand_i = 32'h1234_5678;
        #1;
        chk("kill_blocks_ready", ready_o, 0);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0; kill_i = 1'b0;
        chk("kill_no_accept", busy_o, 0);

        // Synchronous reset in the middle of a scan.
        do_op(2'b00, 32'h0000_0F00, 0);
        @(negedge clk_i);
        valid_i = 1'b1; operation_i = 2'b10; operand_i = 32'hAAAA_5555;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("rst_mid_ready", ready_o, 0);
        @(posedge clk_i);
        #1;
        chk("rst_mid_valid", valid_o, 0);
        chk("rst_mid_result", result_o, 0);
        chk("rst_mid_busy", busy_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 4))
                0:       v = 32'h0;
                1:       v = 32'h1 << $urandom_range(0, 31);
                2:       v = $urandom >> $urandom_range(0, 31);
                3:       v = $urandom << $urandom_range(0, 31);
                default: v = $urandom;
            endcase
            do_op(2'($urandom_range(0, 3)), v, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bmu_count_sequencer.md
Name: bmu_count_sequencer

Overview:
- Iterative sequencer for the bit-manipulation count operations CLZ, CTZ and CPOP.
- Scans a latched operand one nibble per cycle, MSB nibble first, and accumulates per-nibble counts.
- CLZ/CTZ stop early at the first non-zero nibble; CPOP always scans every nibble.
- Sits in the integer execution unit's miscellaneous path, between issue (valid/ready in) and writeback (valid/ready out).

Parameters:
- XLEN, 32, operand width; must be 32 or 64 (a multiple of 4).
- NIBBLES, XLEN/4, derived constant, not overridable.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous reset, active-high.
- valid_i  input  1  issue request valid.
- ready_o  output  1  sequencer can accept a request.
- operand_i  input  XLEN  source operand.
- operation_i  input  2  CLZ=2'b00, CTZ=2'b01, CPOP=2'b10, 2'b11 reserved.
- kill_i  input  1  flush; abandons any in-flight operation.
- valid_o  output  1  result valid.
- ready_i  input  1  writeback accepts the result.
- result_o  output  XLEN  count, zero-extended.
- busy_o  output  1  state is not IDLE.

Behaviour:
- Reset (rst_i high at an edge):
  - state = IDLE, valid_o = 0, result_o = 0, accumulator = 0, pointer = NIBBLES-1.
  - ready_o = 0 while rst_i is high.
- ready_o = (state == IDLE) & ~rst_i & ~kill_i. This is combinational; there is no accept while a result is held.
- FSM states: IDLE, SCAN, DONE.
- IDLE, accept on valid_i & ready_o:
  - Latch the operand. For CTZ, latch the bit-reversed operand so CTZ reduces to CLZ.
  - Latch the operation, clear the accumulator, set pointer = NIBBLES-1.
  - Next state is SCAN. For the reserved op, go directly to DONE with result 0.
- SCAN, each cycle examines nibble[pointer]:
  - CLZ/CTZ, nibble all-zero:
    - acc += 4.
    - If pointer == 0, go to DONE (result = XLEN).
    - Else pointer--.
  - CLZ/CTZ, nibble non-zero: acc += leading-zero count of the nibble (0..3), go to DONE.
  - CPOP: acc += popcount(nibble) (0..4). If pointer == 0, go to DONE; else pointer--.
- DONE:
  - valid_o = 1 and result_o = acc, both registered. They are stable until handshake.
  - valid_o & ready_i moves to IDLE and deasserts valid_o on the next cycle.
- Latency, accept edge to valid_o high:
  - CLZ/CTZ: k+1 cycles, where k is the number of nibbles scanned (1..NIBBLES).
  - CPOP: NIBBLES+1 cycles.
  - Reserved op: 1 cycle.
- Accumulator width is $clog2(XLEN)+1 bits. The maximum value XLEN must be representable.
- Pointer width is $clog2(NIBBLES) bits. The pointer never wraps: termination is checked at pointer == 0 before any decrement.
- kill_i in any state forces state = IDLE and valid_o = 0 on the next edge. Partial results are discarded.
- kill_i takes priority over an accept in the same cycle; the request is not taken.
- kill_i in DONE with ready_i high: the result is dropped, not counted as transferred.
- rst_i takes priority over kill_i, which takes priority over the handshake.
- busy_o = (state != IDLE).
- valid_i while not ready: ignored. The issuer must hold the request.

Decomposition:
- Shared package bmu_pkg holds:
  - typedef enum logic [1:0] count_op_t {CLZ, CTZ, CPOP, RSVD}.
  - typedef enum logic [1:0] count_state_t {IDLE, SCAN, DONE}.
  - Function bit_reverse(XLEN).
- One sub-module, nibble_scan_unit (combinational):
  - Input: 4-bit nibble.
  - Outputs: all_zero, lz_count[1:0], pop_count[2:0].
  - Instantiated once, fed by the pointer-selected nibble mux.

Test Plan:
- XLEN=32, CLZ of 32'h8000_0000 -> 1 SCAN cycle, valid_o two cycles after accept, result 0.
- CLZ of 32'h0000_0001 -> 8 SCAN cycles, result 31; CLZ of 32'h0 -> 8 SCAN cycles, result 32.
- CTZ of 32'h0000_0100 -> result 8 after 3 SCAN cycles; CTZ of 32'h0 -> result 32.
- CPOP of 32'hF0F0_00FF -> 8 SCAN cycles, result 16; CPOP of 32'hFFFF_FFFF -> result 32.
- Backpressure: CLZ 32'h0010_0000 with ready_i low for 5 cycles -> result 11 held stable, ready_o low throughout; ready_i high -> IDLE next cycle, ready_o high.
- Flush and reset:
  - kill_i in cycle 3 of a CPOP -> valid_o never asserts, IDLE next cycle.
  - kill_i concurrent with valid_i -> not accepted.
  - rst_i mid-SCAN -> all outputs at reset values next cycle.
  - Reserved op -> result 0 after 1 cycle.
